// File: rtl/reg_writeback.sv
// Write-back arbiter: merges never-stalled ALU results with buffered LSU results
// into one registered register-file write port, and keeps the RAW busy scoreboard.
module reg_writeback #(
   parameter int cDataWidth  = 32,
   parameter int cRegNum     = 32,
   parameter int cRegSelBitW = 5,
   parameter int cLsuDepth   = 2
) (
   input  logic                   iClk,
   input  logic                   iRst,
   input  logic                   iAluValid,
   input  logic [cRegSelBitW-1:0] iAluRd,
   input  logic [cDataWidth-1:0]  iAluData,
   input  logic                   iLsuValid,
   output logic                   oLsuReady,
   input  logic [cRegSelBitW-1:0] iLsuRd,
   input  logic [cDataWidth-1:0]  iLsuData,
   input  logic                   iIssueEn,
   input  logic [cRegSelBitW-1:0] iIssueRd,
   output logic [cRegNum-1:0]     oBusy,
   output logic [cRegSelBitW:0]   rdCntrl,
   output logic [cDataWidth-1:0]  rdData,
   output logic                   oFwdValid,
   output logic [cRegSelBitW-1:0] oFwdAddr,
   output logic [cDataWidth-1:0]  oFwdData
);

   localparam int cPtrW = (cLsuDepth > 1) ? $clog2(cLsuDepth) : 1;
   localparam int cCntW = cPtrW + 1;

   logic [cRegSelBitW-1:0] fifoRd_q   [cLsuDepth];
   logic [cDataWidth-1:0]  fifoData_q [cLsuDepth];
   logic [cPtrW-1:0]       wrPtr_q, wrPtr_d;
   logic [cPtrW-1:0]       rdPtr_q, rdPtr_d;
   logic [cCntW-1:0]       count_q, count_d;

   logic                   wrEn_q, wrEn_d;
   logic [cRegSelBitW-1:0] wrAddr_q, wrAddr_d;
   logic [cDataWidth-1:0]  wrData_q, wrData_d;
   logic [cRegNum-1:0]     busy_q, busy_d;

   logic                   push;
   logic                   pop;
   logic                   fifoEmpty;
   logic                   selValid;
   logic [cRegSelBitW-1:0] selRd;
   logic [cDataWidth-1:0]  selData;

   assign fifoEmpty = (count_q == '0);
   assign oLsuReady = (count_q != cCntW'(cLsuDepth));
   assign push      = iLsuValid & oLsuReady;
   assign pop       = ~iAluValid & ~fifoEmpty;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + cPtrW'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + cPtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + cCntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - cCntW'(1);
      end
   end

   // Storage needs no reset: entries are only read while the count covers them.
   always_ff @(posedge iClk) begin
      if (push) begin
         fifoRd_q[wrPtr_q]   <= iLsuRd;
         fifoData_q[wrPtr_q] <= iLsuData;
      end
   end

   always_comb begin
      selValid = 1'b0;
      selRd    = '0;
      selData  = '0;
      if (iAluValid) begin
         selValid = 1'b1;
         selRd    = iAluRd;
         selData  = iAluData;
      end else if (!fifoEmpty) begin
         selValid = 1'b1;
         selRd    = fifoRd_q[rdPtr_q];
         selData  = fifoData_q[rdPtr_q];
      end
   end

   // Writes to x0 are swallowed; address and data hold while the port is idle.
   always_comb begin
      wrEn_d   = selValid && (selRd != '0);
      wrAddr_d = wrAddr_q;
      wrData_d = wrData_q;
      if (wrEn_d) begin
         wrAddr_d = selRd;
         wrData_d = selData;
      end
   end

   // Clear on the committed write first so a same-cycle issue re-sets the bit.
   always_comb begin
      busy_d = busy_q;
      if (wrEn_q) begin
         busy_d[wrAddr_q] = 1'b0;
      end
      if (iIssueEn && (iIssueRd != '0)) begin
         busy_d[iIssueRd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         wrEn_q   <= 1'b0;
         wrAddr_q <= '0;
         wrData_q <= '0;
         busy_q   <= '0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         wrEn_q   <= wrEn_d;
         wrAddr_q <= wrAddr_d;
         wrData_q <= wrData_d;
         busy_q   <= busy_d;
      end
   end

   assign rdCntrl   = {wrEn_q, wrAddr_q};
   assign rdData    = wrData_q;
   assign oFwdValid = wrEn_q;
   assign oFwdAddr  = wrAddr_q;
   assign oFwdData  = wrData_q;
   assign oBusy     = busy_q;

endmodule
